// File: rtl/sayeh_memory.sv
// Word-addressed 16-bit data memory for the Sayeh CPU bus, with a programmable
// wait-state handshake. Define MEM_RANGE_CHECK_EN to flag accesses above the depth.
module sayeh_memory #(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        ExternalReset,
  input  logic        ReadMem,
  input  logic        WriteMem,
  input  logic [15:0] Addressbus,
  inout  wire  [15:0] Databus,
  output logic        MemDataready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, READY, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [15:0]             wdata_q;
  logic [15:0]             rdata_q;
  logic                    wr_q;
  logic                    oor_q;
  logic                    oor_req;
  logic                    req_rd, req_wr, start, held, to_ready;

  logic [15:0] mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
  generate
    if (ADDR_WIDTH < 16) begin : g_hi
      assign oor_req = |Addressbus[15:ADDR_WIDTH];
    end else begin : g_full
      assign oor_req = 1'b0;
    end
  endgenerate
`else
  // Upper address bits are intentionally ignored so accesses alias modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^Addressbus;
  assign oor_req        = 1'b0;
`endif

  // Both strobes high together is a protocol error and never starts an access.
  assign req_rd   = ReadMem & ~WriteMem;
  assign req_wr   = WriteMem & ~ReadMem;
  assign start    = (state_q == IDLE) && (req_rd || req_wr);
  assign held     = wr_q ? WriteMem : ReadMem;
  assign to_ready = (state_q == BUSY) && (state_d == READY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_rd || req_wr) begin
          state_d = BUSY;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      BUSY: begin
        if (!held)            state_d = IDLE;
        else if (cnt_q == '0) state_d = READY;
        else                  cnt_d   = cnt_q - 4'd1;
      end
      READY: state_d = HOLD;
      HOLD: begin
        if (!ReadMem && !WriteMem) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ExternalReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        addr_q  <= Addressbus[ADDR_WIDTH-1:0];
        wdata_q <= req_wr ? Databus : 16'h0000;
        wr_q    <= req_wr;
        oor_q   <= oor_req;
      end
      // Registered read so Databus holds steady for the whole READY cycle.
      if (to_ready)
        rdata_q <= oor_q ? 16'hFFFF : mem[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!ExternalReset && state_q == READY && wr_q && !oor_q)
      mem[addr_q] <= wdata_q;
  end

  assign MemDataready = !ExternalReset && (state_q == READY);
  assign Databus      = (!ExternalReset && state_q == READY && !wr_q) ? rdata_q : 16'hzzzz;

endmodule
